// File: rtl/light_bar_pkg.sv
// light_pkg: shared types and helpers for the light_bar playfield.
//   state_t     : round state (PLAY, WIN_L, WIN_R)
//   onehot_pos  : N-bit one-hot image of a cell index, returned in a 32-bit
//                 container (N is at most 32); callers keep the low N bits.
package light_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2
  } state_t;

  localparam int unsigned MAX_CELLS = 32;

  function automatic logic [MAX_CELLS-1:0] onehot_pos(input int unsigned p,
                                                     input int unsigned n);
    logic [MAX_CELLS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_CELLS; i++) begin
      if (i < n && i == p) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/light_bar_if.sv
// light_bar_if: key inputs and display/score outputs of the playfield.
//   L, R, Restart          : driven by the master (key logic / bench)
//   leds, pos, winL, winR,
//   scoreL, scoreR         : driven by the slave (light_bar)
// N and SCORE_W must match the parameters of the attached light_bar.
interface light_bar_if #(
  parameter int N       = 9,
  parameter int SCORE_W = 3
);
  localparam int PW = $clog2(N);

  logic               L;
  logic               R;
  logic               Restart;
  logic [N-1:0]       leds;
  logic [PW-1:0]      pos;
  logic               winL;
  logic               winR;
  logic [SCORE_W-1:0] scoreL;
  logic [SCORE_W-1:0] scoreR;

  modport master (
    output L, R, Restart,
    input  leds, pos, winL, winR, scoreL, scoreR
  );

  modport slave (
    input  L, R, Restart,
    output leds, pos, winL, winR, scoreL, scoreR
  );
endinterface

// File: rtl/light_bar_key_edge.sv
// key_edge: rising-edge detector for one synchronised key level.
//   Clock, RST (sync, active-high), key -> press (one cycle per rising edge)
// The previous sample resets to 1 so a key held through reset is not a press.
module key_edge (
  input  logic Clock,
  input  logic RST,
  input  logic key,
  output logic press
);
  logic keyPrev;

  always_ff @(posedge Clock) begin
    if (RST) keyPrev <= 1'b1;
    else     keyPrev <= key;
  end

  assign press = key & ~keyPrev;
endmodule

// File: rtl/light_bar.sv
// light_bar: N-cell tug-of-war playfield with one lit cell.
//   Clock, RST (sync, active-high)
//   bus (slave): L/R keys, Restart in; leds, pos, winL, winR, scoreL, scoreR out
// Parameters: N cells, CENTER home cell, WRAP (1 = endless scroller, no wins),
// SCORE_W width of the saturating win counters.
//
// state | meaning
// PLAY  | lit cell moves on presses
// WIN_L | left player won; leds dark until Restart
// WIN_R | right player won; leds dark until Restart
module light_bar
  import light_pkg::*;
#(
  parameter int N       = 9,
  parameter int CENTER  = N / 2,
  parameter int WRAP    = 0,
  parameter int SCORE_W = 3
) (
  input  logic       Clock,
  input  logic       RST,
  light_bar_if.slave bus
);
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0]      HOME = PW'(CENTER);
  localparam logic [PW-1:0]      LAST = PW'(N - 1);
  localparam logic [SCORE_W-1:0] SMAX = {SCORE_W{1'b1}};

  state_t             state, stateNext;
  logic [PW-1:0]      pos, posNext;
  logic [SCORE_W-1:0] scoreL, scoreLNext;
  logic [SCORE_W-1:0] scoreR, scoreRNext;
  logic               pressL, pressR;
  logic [MAX_CELLS-1:0] cellVec;

  key_edge uEdgeL (.Clock(Clock), .RST(RST), .key(bus.L), .press(pressL));
  key_edge uEdgeR (.Clock(Clock), .RST(RST), .key(bus.R), .press(pressR));

  always_ff @(posedge Clock) begin
    if (RST) begin
      state  <= PLAY;
      pos    <= HOME;
      scoreL <= '0;
      scoreR <= '0;
    end else begin
      state  <= stateNext;
      pos    <= posNext;
      scoreL <= scoreLNext;
      scoreR <= scoreRNext;
    end
  end

  always_comb begin
    stateNext  = state;
    posNext    = pos;
    scoreLNext = scoreL;
    scoreRNext = scoreR;
    if (bus.Restart) begin
      // Restart wins over any coincident press, in every state.
      stateNext = PLAY;
      posNext   = HOME;
    end else if (state == PLAY && (pressL ^ pressR)) begin
      // Simultaneous presses cancel, hence the XOR.
      if (pressL) begin
        if (pos != LAST)    posNext = pos + PW'(1);
        else if (WRAP != 0) posNext = '0;
        else begin
          stateNext = WIN_L;
          if (scoreL != SMAX) scoreLNext = scoreL + SCORE_W'(1);
        end
      end else begin
        if (pos != '0)      posNext = pos - PW'(1);
        else if (WRAP != 0) posNext = LAST;
        else begin
          stateNext = WIN_R;
          if (scoreR != SMAX) scoreRNext = scoreR + SCORE_W'(1);
        end
      end
    end
  end

  assign cellVec    = onehot_pos(32'(pos), unsigned'(N));
  assign bus.leds   = (state == PLAY) ? cellVec[N-1:0] : '0;
  assign bus.pos    = pos;
  assign bus.winL   = (state == WIN_L);
  assign bus.winR   = (state == WIN_R);
  assign bus.scoreL = scoreL;
  assign bus.scoreR = scoreR;
endmodule

// File: doc/light_bar.md
# light_bar

Parametrised N-cell playfield for the tug-of-war LED game. It replaces the per-cell light FSM chain with a single block that holds one lit position, moves it on debounced key presses, and detects wins at either end. An optional wrap mode turns the bar into an endless scroller. It also keeps saturating per-side win counts for the HEX score display.

## Interface
Parameters:
- N, 9: number of LED cells; legal range 3..32.
- CENTER, N/2: home cell index after reset or restart; must satisfy 0 ≤ CENTER < N.
- WRAP, 0: 1 = position wraps at the ends and no win is ever declared; 0 = win mode.
- SCORE_W, 3: width of each win counter.

Ports:
- Clock, in, 1: system clock, 50 MHz.
- RST, in, 1: synchronous, active-high reset.
- L, in, 1: left key level, already synchronised, 1 = pressed.
- R, in, 1: right key level, already synchronised, 1 = pressed.
- Restart, in, 1: level; starts a new round and keeps the scores.
- leds, out, N: one-hot lit cell. Bit N-1 is the leftmost cell. All zero while a win is held.
- pos, out, $clog2(N): current cell index.
- winL, out, 1: left player has won this round (sticky).
- winR, out, 1: right player has won this round (sticky).
- scoreL, out, SCORE_W: saturating count of left wins.
- scoreR, out, SCORE_W: saturating count of right wins.

## Operation
- Press detection:
  - Each key has a previous-sample register; pressL = L & ~L_prev, and pressR likewise.
  - Holding a key produces exactly one press.
  - The previous-sample registers reset to 1, so a key held through reset is not counted as a press.
- States are PLAY, WIN_L and WIN_R.
- In PLAY, priority order (highest first) is RST, then Restart, then presses:
  - Restart: pos ← CENTER.
  - pressL & pressR in the same cycle: no move (the presses cancel).
  - pressL only: pos+1. If pos == N-1:
    - WRAP=0: go to WIN_L and increment scoreL.
    - WRAP=1: pos ← 0.
  - pressR only: pos-1. If pos == 0:
    - WRAP=0: go to WIN_R and increment scoreR.
    - WRAP=1: pos ← N-1.
- In WIN_L / WIN_R:
  - Presses are ignored.
  - leds = 0 and the matching win flag is 1.
  - pos holds its last value.
  - Restart → PLAY with pos ← CENTER, win flags cleared, scores kept.
- Scores:
  - Saturate at 2^SCORE_W−1; they never wrap.
  - Cleared only by RST.
- With WRAP=1, the FSM never leaves PLAY. winL, winR, scoreL and scoreR stay 0.
- leds is decoded combinationally from pos and the state; it is never stored separately.

## Timing
- Reset values:
  - state = PLAY, pos = CENTER, leds = one-hot(CENTER).
  - winL = winR = 0, scoreL = scoreR = 0.
  - L_prev = R_prev = 1.
- Press latency: a key that goes high before edge k, and was low at edge k-1, moves pos at edge k. leds is visible one cycle after the key rises.
- A win transition and its score increment happen on the same edge as the winning press.
- Restart acts at the next edge. A press coincident with Restart is dropped.
- RST asserted mid-round or mid-win returns to the full reset values at the next edge, overriding all other inputs.
- A key must be released, sampled low for at least one edge, then pressed again to register a second press.

## Structure
- Package light_pkg holds the state enum typedef (PLAY, WIN_L, WIN_R) and a function onehot_pos(pos, N) returning the N-bit one-hot vector.
- Sub-module key_edge (inputs Clock, RST, key; output press) is instantiated twice for L and R. It contains the previous-sample register with reset value 1.
- The top module light_bar contains the FSM, the pos register, the score counters and the leds decode.

## Test plan
- Reset then idle: with N=9 after RST, leds = 9'b000010000, pos = 4, winL = winR = 0, scores = 0. Holding L through the reset deassertion produces no move.
- Hold L high for 10 cycles: pos 4 → 5 exactly once, leds = 9'b000100000.
- Pulse L five times from the centre (low/high alternating): pos reaches 8 after four pulses. The fifth pulse gives winL = 1, leds = 0, scoreL = 1, and further R pulses have no effect.
- Same edge pressL & pressR: pos unchanged. Restart asserted together with pressL: pos = CENTER, press dropped.
- WRAP=1, N=5, CENTER=0: one R pulse gives pos = 4, leds = 5'b10000. One L pulse gives pos = 0 and no win flag.
- SCORE_W=2, with six left wins separated by Restart: scoreL goes 1, 2, 3, 3, 3, 3. RST mid-round then clears the scores and recentres.
